// File: rtl/jtag_run_scheduler.sv
// Sequences JTAG vector runs: shadows the run setup, issues one play pass per repeat with idle gaps,
// times the ADC trigger per pass and keeps sticky status. Optional play watchdog: JTAG_RUN_WATCHDOG_EN.
module jtag_run_scheduler #(
  parameter int unsigned A_WIDTH    = 12,
  parameter int unsigned R_WIDTH    = 16,
  parameter int unsigned D_WIDTH    = 16,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned WDOG_WIDTH = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic               cmd_clear,
  input  logic [A_WIDTH-1:0] vector_start,
  input  logic [A_WIDTH-1:0] vector_end,
  input  logic [R_WIDTH-1:0] vector_number_repeat,
  input  logic [D_WIDTH-1:0] adc_start_delay,
  output logic               play_req,
  output logic [A_WIDTH-1:0] play_addr_lo,
  output logic [A_WIDTH-1:0] play_addr_hi,
  input  logic               play_done,
  output logic               wait_state,
  output logic               adc_start,
  output logic               adc_sequence_one,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [R_WIDTH-1:0] passes_done
);

  localparam int unsigned G_WIDTH  = 8;
  localparam int unsigned RX_WIDTH = R_WIDTH + 1;
  localparam logic [G_WIDTH-1:0] GAP_LAST = G_WIDTH'(GAP_CYCLES - 1);

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_WINDOW = 2'b01;
  localparam logic [1:0] ERR_ABORT  = 2'b10;
  localparam logic [1:0] ERR_WDOG   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ARM   = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [R_WIDTH-1:0] target_q;
  logic [D_WIDTH-1:0] delay_q;
  logic [D_WIDTH-1:0] dcnt_q;
  logic [G_WIDTH-1:0] gcnt_q;

  logic               start_hit, abort_hit, pass_end, last_pass, bad_window, wdog_expire;

  logic               play_req_d, adc_start_d, wait_state_d, busy_d, adc_seq_d;
  logic               done_d, error_d;
  logic [1:0]         err_code_d;
  logic [R_WIDTH-1:0] passes_d;

  assign start_hit  = (state_q == S_IDLE) && cmd_start;
  assign abort_hit  = (state_q != S_IDLE) && cmd_abort;
  assign pass_end   = (state_q == S_PLAY) && play_done && !abort_hit;
  assign last_pass  = ({1'b0, passes_done} + RX_WIDTH'(1)) == {1'b0, target_q};
  assign bad_window = (state_q == S_CHECK) && (play_addr_lo > play_addr_hi);

`ifdef JTAG_RUN_WATCHDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q;

  // Cleared as each pass is requested, counts only while the player is busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (state_d == S_ARM) begin
      wdog_q <= '0;
    end else if ((state_q == S_PLAY) && (wdog_q != '1)) begin
      wdog_q <= wdog_q + WDOG_WIDTH'(1);
    end
  end

  assign wdog_expire = (state_q == S_PLAY) && !play_done && (wdog_q == '1);
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_WIDTH;
  assign wdog_expire     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other event
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_start) state_d = S_CHECK;
      S_CHECK: state_d = bad_window ? S_IDLE : S_ARM;
      S_ARM:   state_d = S_PLAY;
      S_PLAY: begin
        if (play_done) begin
          state_d = last_pass ? S_DONE : S_GAP;
        end else if (wdog_expire) begin
          state_d = S_IDLE;
        end
      end
      S_GAP:   if (gcnt_q == '0) state_d = S_ARM;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
    end
  end

  // Output decode: registered outputs follow the state being entered
  always_comb begin
    play_req_d   = 1'b0;
    adc_start_d  = 1'b0;
    wait_state_d = 1'b1;
    busy_d       = 1'b0;
    adc_seq_d    = adc_sequence_one;
    done_d       = done;
    error_d      = error;
    err_code_d   = err_code;
    passes_d     = passes_done;

    case (state_d)
      S_ARM: begin
        play_req_d   = 1'b1;
        wait_state_d = 1'b0;
        busy_d       = 1'b1;
        adc_seq_d    = ~passes_done[0];
        adc_start_d  = (delay_q == '0);
      end
      S_PLAY: begin
        wait_state_d = 1'b0;
        busy_d       = 1'b1;
        adc_start_d  = (dcnt_q == D_WIDTH'(1));
      end
      S_GAP:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase

    if (start_hit || ((state_q == S_IDLE) && cmd_clear)) begin
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = ERR_NONE;
    end
    if (start_hit) begin
      passes_d = '0;
    end
    if (bad_window) begin
      error_d    = 1'b1;
      err_code_d = ERR_WINDOW;
    end
    if (pass_end && (passes_done != '1)) begin
      passes_d = passes_done + R_WIDTH'(1);
    end
    if (wdog_expire) begin
      error_d    = 1'b1;
      err_code_d = ERR_WDOG;
    end
    if (abort_hit) begin
      done_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = ERR_ABORT;
    end
  end

  // Shadow registers, pass counters and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      play_addr_lo     <= '0;
      play_addr_hi     <= '0;
      target_q         <= '0;
      delay_q          <= '0;
      dcnt_q           <= '0;
      gcnt_q           <= '0;
      play_req         <= 1'b0;
      adc_start        <= 1'b0;
      wait_state       <= 1'b1;
      busy             <= 1'b0;
      adc_sequence_one <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      err_code         <= ERR_NONE;
      passes_done      <= '0;
    end else begin
      if (start_hit) begin
        play_addr_lo <= vector_start;
        play_addr_hi <= vector_end;
        target_q     <= (vector_number_repeat == '0) ? R_WIDTH'(1) : vector_number_repeat;
        delay_q      <= adc_start_delay;
      end

      // Delay counter parks at zero so the ADC trigger cannot repeat within a pass
      if (state_d == S_ARM) begin
        dcnt_q <= delay_q;
      end else if (dcnt_q != '0) begin
        dcnt_q <= dcnt_q - D_WIDTH'(1);
      end

      if ((state_d == S_GAP) && (state_q != S_GAP)) begin
        gcnt_q <= GAP_LAST;
      end else if (gcnt_q != '0) begin
        gcnt_q <= gcnt_q - G_WIDTH'(1);
      end

      play_req         <= play_req_d;
      adc_start        <= adc_start_d;
      wait_state       <= wait_state_d;
      busy             <= busy_d;
      adc_sequence_one <= adc_seq_d;
      done             <= done_d;
      error            <= error_d;
      err_code         <= err_code_d;
      passes_done      <= passes_d;
    end
  end

endmodule
